// File: rtl/mem_map_pkg.sv
// Shared address map for the data-bus responder:
// MMIO window base, register offsets and STATUS layout.
package mem_map;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_OUT    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_CNT   = 4;

  function automatic logic [3:0] sat4(input logic [31:0] n);
    return (n > 32'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; a push while full is taken only
// when a pop frees the head in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (PW+1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign rdata  = empty ? '0 : r_mem[r_rd];
  assign count  = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder: zero-wait word RAM plus an MMIO
// window with cycle counter, output FIFO and status.
module data_bus_responder #(
  parameter int          RAM_WORDS  = 1024,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = mem_map::MMIO_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);

  import mem_map::*;

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_cycle;
  logic          r_ovf;

  logic          w_ram_hit;
  logic          w_mmio_hit;
  logic [3:0]    w_off;
  logic [AW-1:0] w_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_st_wr;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;

  assign w_ram_hit  = (aluout >> (AW + 2)) == 32'd0;
  assign w_mmio_hit = aluout[31:4] == MMIO_BASE[31:4];
  assign w_off      = {aluout[3:2], 2'b00};
  assign w_idx      = aluout[AW+1:2];

  assign w_push  = memwrite && w_mmio_hit && (w_off == OFF_OUT);
  assign w_st_wr = memwrite && w_mmio_hit && (w_off == OFF_STATUS);
  assign w_pop   = !w_empty && out_ready;

  assign out_valid = !w_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (w_push),
    .wdata (writedata),
    .full  (w_full),
    .pop   (w_pop),
    .rdata (out_data),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk) begin
    if (memwrite && w_ram_hit) r_ram[w_idx] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      // a dropped push only counts if no pop made room
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
      else if (w_st_wr && writedata[ST_OVF])
        r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_status         = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL]  = w_full;
    w_status[ST_OVF]   = r_ovf;
    w_status[ST_CNT+:4] = sat4(32'(w_count));
  end

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      w_ram_hit:
        readdata = r_ram[w_idx];
      w_mmio_hit && (w_off == OFF_CYCLE):
        readdata = r_cycle;
      w_mmio_hit && (w_off == OFF_STATUS):
        readdata = w_status;
      default:
        readdata = '0;
    endcase
  end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Responder end of the core's data-memory interface: decodes the core's memwrite/aluout/writedata, returns readdata.
- Contains word RAM plus a small MMIO window: free-running cycle counter, output FIFO drained by an external valid/ready consumer, and a status register.
- Sits beside the core at SoC top; the core has no stall input, so reads are zero-wait (combinational) and writes commit on the clock edge.

Parameters:
- RAM_WORDS, 1024, number of 32-bit RAM words; power of 2.
- FIFO_DEPTH, 8, output FIFO entries; power of 2, ≥2.
- MMIO_BASE, 32'hFFFF_0000, byte base address of the MMIO window.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  write strobe from core.
- aluout  in  32  byte address from core.
- writedata  in  32  store data from core.
- readdata  out  32  load data to core, combinational from aluout.
- out_valid  out  1  FIFO head valid.
- out_data  out  32  FIFO head word; 0 when empty.
- out_ready  in  1  consumer accepts head this cycle.

Behaviour:
- Interface (fixed): one clock clk; reset asynchronous, active-low. Assertion (reset=0) immediately clears all state, independent of clk.
- Addressing: aluout[1:0] ignored (word access only).
  - RAM hit: aluout < RAM_WORDS*4; index = aluout[log2(RAM_WORDS)+1:2].
  - MMIO hit: aluout[31:4] == MMIO_BASE[31:4].
  - All other addresses: readdata=0, writes ignored.
- RAM:
  - Asynchronous read; write on clk edge when memwrite & RAM hit.
  - Contents are not reset.
  - Read of the address being written in the same cycle returns the old value.
- MMIO register map (offset from MMIO_BASE):
  - 0x0 CYCLE (RO): 32-bit counter, +1 every clk, wraps FFFFFFFF→0. Reset 0. Writes ignored.
  - 0x4 OUT (WO): memwrite pushes writedata into the FIFO. Reads return 0.
  - 0x8 STATUS (R/W1C):
    - [0] empty
    - [1] full
    - [2] overflow (sticky)
    - [7:4] count (saturates display at 15)
    - all other bits 0
    - A write with writedata[2]=1 clears overflow; other write bits are ignored.
  - 0xC: reads 0, writes ignored.
- Output FIFO:
  - Circular buffer with read/write pointers and a count.
  - Pop when out_valid & out_ready.
  - Push when memwrite & OUT hit.
  - Push while full without a pop in the same cycle: data dropped, overflow set, FIFO unchanged.
  - Push while full with a pop in the same cycle: push accepted, count unchanged, no overflow.
  - Push while empty: data visible on out_data in the next cycle, never the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - out_valid = (count != 0); out_data = head entry, else 0.
- Reset values: CYCLE=0, FIFO empty, overflow=0, out_valid=0, out_data=0. readdata follows the address decode. STATUS after reset reads 0x00000001.
- A push or pop in flight when reset asserts is lost.

Decomposition:
- Shared package `mem_map`: MMIO_BASE, register offsets (OFF_CYCLE=0, OFF_OUT=4, OFF_STATUS=8), STATUS bit positions.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; ports push/wdata/full, pop/rdata/empty, count). The responder instantiates it and handles overflow and decode itself.

Test Plan:
- Reset: drive reset=0 mid-run, then release → CYCLE read 0 at release, then 1, 2, …; STATUS=0x1; out_valid=0.
- RAM: write 0xDEADBEEF to 0x10, read 0x10 → 0xDEADBEEF; read 0x13 → same word; read 0x0010_0000 (unmapped) → 0.
- FIFO order: out_ready=0, push 1..8 → STATUS=0x82 (count 8, full), no overflow. Set out_ready=1 → out_data 1..8 on consecutive cycles, then out_valid=0.
- Overflow and clear:
  - Full FIFO, push 9 with out_ready=0 → STATUS bit2=1, FIFO contents unchanged.
  - Write STATUS with 0x4 → bit2 clears.
- Simultaneous push/pop: full FIFO, push 0xAA with out_ready=1 → head popped, 0xAA accepted as last entry, count stays 8, overflow 0.
- Counter wrap: force CYCLE to 0xFFFFFFFF via bench hierarchy → next cycle 0.
